// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins as static-low, static-high or a shared PWM waveform.
// A prescaled 8-bit period counter sets the phase; duty is shadowed at period wrap.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    duty_shadow_q, duty_shadow_d;
    logic [15:0]   out_q, out_d;
    logic          period_start_q, period_start_d;

    logic          tick;
    logic          boundary;
    logic          pwm_level;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick && (pwm_cnt_q == 8'hFF);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

        // Duty is only picked up on the wrap edge so a period never mixes two duties.
        duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
        period_start_d = boundary;
    end

    // 0xFF is treated as full-on so there is no low step at count 255.
    always_comb begin
        pwm_level = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
        out_d     = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            duty_shadow_q  <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out_7_0      = out_q[7:0];
    assign out_15_8     = out_q[15:8];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scenario tasks plus a per-edge reference model derived
// from the count of clock edges since reset release.
module tb_pwm_peripheral;

    localparam int P   = 4;
    localparam int PER = 256 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] en_out_lo = '0, en_out_hi = '0, en_pwm_lo = '0, en_pwm_hi = '0, duty = '0;
    logic [7:0] out_lo, out_hi;
    logic       ps;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out_7_0         (out_lo),
        .out_15_8        (out_hi),
        .period_start    (ps)
    );

    // Reference: after n edges the count step is (n/P)%256, a new period
    // begins every PER edges and the duty in force is the one seen on that edge.
    int          m_edges;
    logic [7:0]  m_duty_eff;
    logic [15:0] m_out;
    logic        m_ps;

    always @(posedge clk or negedge rst_n) begin : model
        int   step;
        logic lvl;
        if (!rst_n) begin
            m_edges    = 0;
            m_duty_eff = 8'h00;
            m_out      = 16'h0000;
            m_ps       = 1'b0;
        end else begin
            step  = (m_edges / P) % 256;
            lvl   = (m_duty_eff == 8'hFF) || (step < int'(m_duty_eff));
            m_out = {en_out_hi, en_out_lo} & (~{en_pwm_hi, en_pwm_lo} | {16{lvl}});
            m_edges++;
            m_ps = (m_edges % PER) == 0;
            if (m_ps) m_duty_eff = duty;
        end
    end

    // Waits for the next period_start; returns -1 if none within two periods.
    task automatic wait_ps(output int waited);
        waited = -1;
        for (int i = 1; i <= 2 * PER + 4; i++) begin
            @(negedge clk);
            if (ps) begin
                waited = i;
                break;
            end
        end
    endtask

    // Runs one period starting just after a period_start sample; measures pin 0.
    task automatic run_period(input int wr_at, input logic [7:0] wr_val,
                              output int high, output int ps_at, output int bad);
        high  = 0;
        ps_at = -1;
        bad   = 0;
        for (int i = 1; i <= PER; i++) begin
            @(negedge clk);
            if (out_lo[0]) high++;
            if (ps && ps_at < 0) ps_at = i;
            if ({out_hi, out_lo} !== m_out || ps !== m_ps) bad++;
            if (i == wr_at) duty = wr_val;
        end
    endtask

    task automatic test_reset();
        int first_ps, bad, mbad;
        rst_n = 1'b0;
        {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty} = {5{8'hFF}};
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({out_hi, out_lo} !== 16'h0000 || ps !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_hold: %0d cycles with nonzero outputs, required 0", bad);
        end
        rst_n = 1'b1;
        first_ps = -1;
        bad = 0;
        mbad = 0;
        for (int k = 1; k <= PER + 1; k++) begin
            @(negedge clk);
            if (ps && first_ps < 0) first_ps = k;
            if (k <= PER && {out_hi, out_lo} !== 16'h0000) bad++;
            if ({out_hi, out_lo} !== m_out || ps !== m_ps) mbad++;
        end
        checks++;
        if (first_ps !== PER) begin
            failures++;
            $display("FAIL reset_first_ps: at cycle %0d, required %0d", first_ps, PER);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_first_period_low: %0d high cycles, required 0", bad);
        end
        checks++;
        if ({out_hi, out_lo} !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_full_duty_after_wrap: got %h, required ffff", {out_hi, out_lo});
        end
        checks++;
        if (mbad !== 0) begin
            failures++;
            $display("FAIL reset_model: %0d cycles differ from model, required 0", mbad);
        end
        {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty} = '0;
        @(negedge clk);
    endtask

    task automatic test_static();
        en_out_lo = 8'hA5;
        en_out_hi = 8'h3C;
        en_pwm_lo = 8'h00;
        en_pwm_hi = 8'h00;
        @(negedge clk);
        checks++;
        if (out_lo !== 8'hA5 || out_hi !== 8'h3C) begin
            failures++;
            $display("FAIL static_on: got %h_%h, required 3c_a5", out_hi, out_lo);
        end
        en_out_lo = 8'h00;
        en_out_hi = 8'h00;
        @(negedge clk);
        checks++;
        if (out_lo !== 8'h00 || out_hi !== 8'h00) begin
            failures++;
            $display("FAIL static_off: got %h_%h, required 00_00", out_hi, out_lo);
        end
        en_pwm_lo = 8'hFF;
        en_pwm_hi = 8'hFF;
        duty      = 8'hFF;
        @(negedge clk);
        checks++;
        if ({out_hi, out_lo} !== 16'h0000) begin
            failures++;
            $display("FAIL static_pwm_ignored: got %h, required 0000", {out_hi, out_lo});
        end
        {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty} = '0;
    endtask

    task automatic test_pwm50();
        int w, high, ps_at, bad;
        en_out_lo = 8'h01;
        en_pwm_lo = 8'h01;
        duty      = 8'h80;
        wait_ps(w);
        checks++;
        if (w < 0) begin
            failures++;
            $display("FAIL pwm50_wait: no period_start within %0d cycles", 2 * PER + 4);
        end
        run_period(-1, 8'h00, high, ps_at, bad);
        checks++;
        if (high !== 512) begin
            failures++;
            $display("FAIL pwm50_high: %0d high cycles, required 512", high);
        end
        checks++;
        if (ps_at !== PER) begin
            failures++;
            $display("FAIL pwm50_spacing: period_start at %0d, required %0d", ps_at, PER);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL pwm50_model: %0d cycles differ from model, required 0", bad);
        end
    endtask

    task automatic test_extremes();
        int w, high, ps_at, bad;
        logic [7:0] d;
        int exp_high;
        for (int t = 0; t < 3; t++) begin
            d = (t == 0) ? 8'h00 : 8'hFF;
            exp_high = (t == 0) ? 0 : PER;
            duty = d;
            wait_ps(w);
            run_period(-1, 8'h00, high, ps_at, bad);
            checks++;
            if (high !== exp_high || bad !== 0 || ps_at !== PER) begin
                failures++;
                $display("FAIL extreme_duty_%h: high=%0d model_diffs=%0d ps_at=%0d, required high=%0d diffs=0 ps_at=%0d",
                         d, high, bad, ps_at, exp_high, PER);
            end
        end
        en_pwm_lo = 8'h00;
        duty      = 8'h00;
        wait_ps(w);
        run_period(-1, 8'h00, high, ps_at, bad);
        checks++;
        if (high !== PER || bad !== 0) begin
            failures++;
            $display("FAIL extreme_static_high: high=%0d model_diffs=%0d, required high=%0d diffs=0", high, bad, PER);
        end
        en_pwm_lo = 8'h01;
    endtask

    task automatic test_mid_update();
        int w, high, ps_at, bad;
        duty = 8'h40;
        wait_ps(w);
        run_period(16 * P, 8'hC0, high, ps_at, bad);
        checks++;
        if (high !== 256 || bad !== 0) begin
            failures++;
            $display("FAIL mid_update_current: high=%0d diffs=%0d, required high=256 diffs=0", high, bad);
        end
        run_period(-1, 8'h00, high, ps_at, bad);
        checks++;
        if (high !== 768 || bad !== 0) begin
            failures++;
            $display("FAIL mid_update_next: high=%0d diffs=%0d, required high=768 diffs=0", high, bad);
        end
        // Write lands on the wrap edge itself.
        run_period(PER - 1, 8'h20, high, ps_at, bad);
        checks++;
        if (high !== 768 || bad !== 0) begin
            failures++;
            $display("FAIL boundary_write_current: high=%0d diffs=%0d, required high=768 diffs=0", high, bad);
        end
        run_period(-1, 8'h00, high, ps_at, bad);
        checks++;
        if (high !== 32 * P || bad !== 0) begin
            failures++;
            $display("FAIL boundary_write_next: high=%0d diffs=%0d, required high=%0d diffs=0", high, bad, 32 * P);
        end
    endtask

    task automatic test_random();
        int high, ps_at, bad, exp_high, wr_at;
        logic [7:0] cur_duty, nxt_duty;
        cur_duty = duty;
        for (int r = 0; r < 6; r++) begin
            en_out_lo = 8'($urandom);
            en_out_hi = 8'($urandom);
            en_pwm_lo = 8'($urandom);
            en_pwm_hi = 8'($urandom);
            nxt_duty  = 8'($urandom);
            wr_at     = $urandom_range(1, PER - 1);
            if (!en_out_lo[0])          exp_high = 0;
            else if (!en_pwm_lo[0])     exp_high = PER;
            else if (cur_duty == 8'hFF) exp_high = PER;
            else                        exp_high = int'(cur_duty) * P;
            run_period(wr_at, nxt_duty, high, ps_at, bad);
            checks++;
            if (high !== exp_high || bad !== 0 || ps_at !== PER) begin
                failures++;
                $display("FAIL random_%0d: high=%0d diffs=%0d ps_at=%0d, required high=%0d diffs=0 ps_at=%0d",
                         r, high, bad, ps_at, exp_high, PER);
            end
            cur_duty = nxt_duty;
        end
    endtask

    task automatic test_reset_mid();
        int w, high, first_ps, bad;
        int ps_at;
        en_out_lo = 8'h01;
        en_pwm_lo = 8'h01;
        en_out_hi = 8'hFF;
        en_pwm_hi = 8'h00;
        duty      = 8'h80;
        wait_ps(w);
        wait_ps(w);
        repeat (16'h7F * P + 1) @(negedge clk);
        checks++;
        if (out_lo !== 8'h01 || out_hi !== 8'hFF) begin
            failures++;
            $display("FAIL reset_mid_pre: got %h_%h, required ff_01", out_hi, out_lo);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_hi, out_lo} !== 16'h0000 || ps !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got %h ps=%b, required 0000 ps=0", {out_hi, out_lo}, ps);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        high = 0;
        first_ps = -1;
        bad = 0;
        for (int k = 1; k <= PER; k++) begin
            @(negedge clk);
            if (out_lo[0]) high++;
            if (ps && first_ps < 0) first_ps = k;
            if ({out_hi, out_lo} !== m_out || ps !== m_ps) bad++;
        end
        checks++;
        if (high !== 0 || first_ps !== PER || bad !== 0) begin
            failures++;
            $display("FAIL reset_mid_first_period: high=%0d ps_at=%0d diffs=%0d, required 0/%0d/0", high, first_ps, bad, PER);
        end
        run_period(-1, 8'h00, high, ps_at, bad);
        checks++;
        if (high !== 512 || bad !== 0 || ps_at !== PER) begin
            failures++;
            $display("FAIL reset_mid_second_period: high=%0d diffs=%0d ps_at=%0d, required 512/0/%0d", high, bad, ps_at, PER);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm50();
        test_extremes();
        test_mid_update();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
